// File: rtl/rfsoc_config_pkg.sv
// Shared constants and types for the RFSoC ADC streaming path.
// Holds the channel count and the burst scheduler's state encoding.
package rfsoc_config;

  localparam int PS_AXIS_WIDTH = 64;
  localparam int NUM_ADC_CH    = 16;

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    GRANT  = 2'd1,
    STREAM = 2'd2
  } sched_state_t;

endpackage

// File: rtl/rr_pick16.sv
// Combinational 16-way round-robin picker.
// Returns the first set request at or after last_id+1, wrapping around.
module rr_pick16 (
  input  logic [15:0] req,
  input  logic [3:0]  last_id,
  output logic        found,
  output logic [3:0]  pick_id,
  output logic [15:0] pick_onehot
);

  // rot[k] holds the request k+1 positions above last_id, so bit 0 has the highest priority
  logic [15:0] rot;
  logic [3:0]  off;

  for (genvar gi = 0; gi < 16; gi++) begin : g_rot
    assign rot[gi] = req[4'(last_id + 4'(gi + 1))];
  end

  always_comb begin
    found = 1'b0;
    off   = 4'd0;
    for (int k = 15; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        off   = 4'(k);
      end
    end
  end

  assign pick_id     = last_id + 4'd1 + off;
  assign pick_onehot = found ? (16'd1 << pick_id) : 16'd0;

endmodule

// File: rtl/axis_mux_scheduler.sv
// Round-robin burst scheduler for the shared 16:1 AXI-Stream mux.
// Drives the one-hot select and gates downstream ready while the mux's registered select settles.
module axis_mux_scheduler
  import rfsoc_config::*;
#(
  parameter int BURST_W     = 16,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  run,
  input  logic [NUM_ADC_CH-1:0] channel_enable,
  input  logic [BURST_W-1:0]    beats_per_grant,
  input  logic [NUM_ADC_CH-1:0] s_axis_tvalid,
  input  logic                  mux_m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [NUM_ADC_CH-1:0] select_out,
  output logic                  mux_m_axis_tready,
  output logic [3:0]            grant_id,
  output logic                  grant_active,
  output logic                  burst_done,
  output logic                  timeout_pulse
);

  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);

  sched_state_t          state_q, state_d;
  logic [NUM_ADC_CH-1:0] select_q, select_d;
  logic [3:0]            grant_id_q, grant_id_d;
  logic [3:0]            last_id_q, last_id_d;
  logic [BURST_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [IDLE_W-1:0]     idle_cnt_q, idle_cnt_d;
  logic                  burst_done_q, burst_done_d;
  logic                  timeout_q, timeout_d;

  logic [NUM_ADC_CH-1:0] req;
  logic                  found;
  logic [3:0]            pick_id;
  logic [NUM_ADC_CH-1:0] pick_onehot;
  logic                  stream_en;
  logic                  beat;

  assign req = channel_enable & s_axis_tvalid;

  rr_pick16 u_pick (
    .req        (req),
    .last_id    (last_id_q),
    .found      (found),
    .pick_id    (pick_id),
    .pick_onehot(pick_onehot)
  );

  // Decoded from the state register only, so ready never depends on tvalid
  assign stream_en = (state_q == STREAM);
  assign beat      = stream_en & mux_m_axis_tvalid & m_axis_tready;

  always_comb begin
    state_d      = state_q;
    select_d     = select_q;
    grant_id_d   = grant_id_q;
    last_id_d    = last_id_q;
    beat_cnt_d   = beat_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    burst_done_d = 1'b0;
    timeout_d    = 1'b0;
    case (state_q)
      ARB: begin
        if (run && found) begin
          select_d   = pick_onehot;
          grant_id_d = pick_id;
          beat_cnt_d = (beats_per_grant == '0) ? BURST_W'(1) : beats_per_grant;
          idle_cnt_d = '0;
          state_d    = GRANT;
        end else begin
          select_d = '0;
        end
      end
      GRANT: state_d = STREAM;
      STREAM: begin
        if (beat) begin
          idle_cnt_d = '0;
          beat_cnt_d = beat_cnt_q - BURST_W'(1);
          if (beat_cnt_q == BURST_W'(1)) begin
            burst_done_d = 1'b1;
            select_d     = '0;
            last_id_d    = grant_id_q;
            state_d      = ARB;
          end
        end else if (idle_cnt_q == IDLE_LAST) begin
          timeout_d  = 1'b1;
          select_d   = '0;
          last_id_d  = grant_id_q;
          idle_cnt_d = '0;
          state_d    = ARB;
        end else begin
          idle_cnt_d = idle_cnt_q + IDLE_W'(1);
        end
      end
      default: begin
        select_d = '0;
        state_d  = ARB;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ARB;
      select_q     <= '0;
      grant_id_q   <= 4'd0;
      last_id_q    <= 4'd15;
      beat_cnt_q   <= '0;
      idle_cnt_q   <= '0;
      burst_done_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      select_q     <= select_d;
      grant_id_q   <= grant_id_d;
      last_id_q    <= last_id_d;
      beat_cnt_q   <= beat_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      burst_done_q <= burst_done_d;
      timeout_q    <= timeout_d;
    end
  end

  assign select_out        = select_q;
  assign grant_id          = grant_id_q;
  assign grant_active      = (state_q != ARB);
  assign burst_done        = burst_done_q;
  assign timeout_pulse     = timeout_q;
  assign mux_m_axis_tready = m_axis_tready & stream_en;

endmodule

// File: tb/tb_axis_mux_scheduler.sv
// Directed bench for axis_mux_scheduler with a registered-select mux model.
// Walks round-robin bursts, timeout, zero burst length, run gating and mid-burst reset.
module tb_axis_mux_scheduler;

  logic        clk = 1'b0;
  logic        resetn;
  logic        run;
  logic [15:0] channel_enable;
  logic [15:0] beats_per_grant;
  logic [15:0] s_axis_tvalid;
  logic        mux_m_axis_tvalid;
  logic        m_axis_tready;
  logic [15:0] select_out;
  logic        mux_m_axis_tready;
  logic [3:0]  grant_id;
  logic        grant_active;
  logic        burst_done;
  logic        timeout_pulse;

  logic [15:0] mux_sel_q = 16'd0;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Mux model: select is registered inside the mux, so its output lags select_out by one cycle
  always @(posedge clk) mux_sel_q <= select_out;
  assign mux_m_axis_tvalid = |(mux_sel_q & s_axis_tvalid);

  axis_mux_scheduler #(.BURST_W(16), .TIMEOUT_CYC(8)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .run              (run),
    .channel_enable   (channel_enable),
    .beats_per_grant  (beats_per_grant),
    .s_axis_tvalid    (s_axis_tvalid),
    .mux_m_axis_tvalid(mux_m_axis_tvalid),
    .m_axis_tready    (m_axis_tready),
    .select_out       (select_out),
    .mux_m_axis_tready(mux_m_axis_tready),
    .grant_id         (grant_id),
    .grant_active     (grant_active),
    .burst_done       (burst_done),
    .timeout_pulse    (timeout_pulse)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // While ready is high the mux must be driving the channel that is currently selected
  always @(negedge clk) begin
    if (mux_m_axis_tready) check_eq("gate_sel", {16'd0, mux_sel_q}, {16'd0, select_out});
  end

  // Entered while the DUT sits in ARB; leaves it back in ARB with burst_done visible
  task automatic run_burst(input logic [15:0] exp_sel, input logic [3:0] exp_id, input int n_beats);
    step();
    check_eq("grant_sel", {16'd0, select_out}, {16'd0, exp_sel});
    check_eq("grant_id", {28'd0, grant_id}, {28'd0, exp_id});
    check_eq("grant_rdy", {31'd0, mux_m_axis_tready}, 32'd0);
    for (int i = 0; i < n_beats; i++) begin
      step();
      check_eq("beat", {30'd0, mux_m_axis_tready, mux_m_axis_tvalid}, 32'd3);
      check_eq("no_done", {31'd0, burst_done}, 32'd0);
    end
    step();
    check_eq("done", {31'd0, burst_done}, 32'd1);
    check_eq("rel_sel", {16'd0, select_out}, 32'd0);
    check_eq("rel_rdy", {31'd0, mux_m_axis_tready}, 32'd0);
    $display("burst ch %0d sel %04h beats %0d", exp_id, exp_sel, n_beats);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; run = 1'b1; channel_enable = 16'hFFFF;
    s_axis_tvalid = 16'h0009; beats_per_grant = 16'd4; m_axis_tready = 1'b1;
    step(); step();
    check_eq("rst_sel", {16'd0, select_out}, 32'd0);
    check_eq("rst_gid", {28'd0, grant_id}, 32'd0);
    check_eq("rst_act", {31'd0, grant_active}, 32'd0);
    check_eq("rst_rdy", {31'd0, mux_m_axis_tready}, 32'd0);
    check_eq("rst_pulses", {30'd0, burst_done, timeout_pulse}, 32'd0);
    resetn = 1'b1;

    // Round robin between channels 0 and 3, four beats each
    run_burst(16'h0001, 4'd0, 4);
    run_burst(16'h0008, 4'd3, 4);
    run_burst(16'h0001, 4'd0, 4);

    // Timeout: channel 5 stops after two beats
    s_axis_tvalid = 16'h0020;
    step();
    check_eq("to_sel", {16'd0, select_out}, 32'h0020);
    check_eq("to_gid", {28'd0, grant_id}, 32'd5);
    step(); check_eq("to_beat1", {31'd0, mux_m_axis_tvalid & mux_m_axis_tready}, 32'd1);
    step(); check_eq("to_beat2", {31'd0, mux_m_axis_tvalid & mux_m_axis_tready}, 32'd1);
    step();
    s_axis_tvalid = 16'h0000;
    for (int i = 0; i < 7; i++) begin
      step();
      check_eq("to_wait", {30'd0, timeout_pulse, grant_active}, 32'd1);
    end
    step();
    check_eq("to_pulse", {31'd0, timeout_pulse}, 32'd1);
    check_eq("to_rel", {16'd0, select_out}, 32'd0);
    check_eq("to_arb", {31'd0, grant_active}, 32'd0);
    check_eq("to_nodone", {31'd0, burst_done}, 32'd0);
    $display("timeout ch 5 after 2 beats");

    // Zero burst length means one beat per grant
    beats_per_grant = 16'd0; s_axis_tvalid = 16'h0009;
    run_burst(16'h0001, 4'd0, 1);
    run_burst(16'h0008, 4'd3, 1);

    // Nothing enabled: no grant ever
    channel_enable = 16'h0000; s_axis_tvalid = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("dis_sel", {15'd0, grant_active, select_out}, 32'd0);
    end
    $display("disabled mask idle");

    // run dropped mid-burst: burst finishes, no new grant until run returns
    channel_enable = 16'hFFFF; s_axis_tvalid = 16'h0004; beats_per_grant = 16'd10;
    step();
    check_eq("run_sel", {16'd0, select_out}, 32'h0004);
    for (int i = 0; i < 10; i++) begin
      step();
      check_eq("run_beat", {31'd0, mux_m_axis_tvalid & mux_m_axis_tready}, 32'd1);
      if (i == 3) run = 1'b0;
    end
    step();
    check_eq("run_done", {31'd0, burst_done}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("run_hold", {15'd0, grant_active, select_out}, 32'd0);
    end
    run = 1'b1;
    step();
    check_eq("run_regrant", {16'd0, select_out}, 32'h0004);
    $display("run gating ch 2 burst 10");

    // Reset during the last beat of a burst
    step();
    for (int i = 0; i < 9; i++) step();
    check_eq("rr_lastbeat", {31'd0, mux_m_axis_tvalid & mux_m_axis_tready}, 32'd1);
    resetn = 1'b0;
    step();
    check_eq("rr_sel", {16'd0, select_out}, 32'd0);
    check_eq("rr_act", {31'd0, grant_active}, 32'd0);
    check_eq("rr_done", {31'd0, burst_done}, 32'd0);
    check_eq("rr_gid", {28'd0, grant_id}, 32'd0);
    resetn = 1'b1;
    // last_id restarts at 15, so channel 2 wins over 15
    s_axis_tvalid = 16'h8004; beats_per_grant = 16'd2;
    run_burst(16'h0004, 4'd2, 2);
    run_burst(16'h8000, 4'd15, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axis_mux_scheduler.md
# axis_mux_scheduler

Round-robin burst scheduler that shares the 16-input AXI-Stream mux between the 16 ADC driver streams. It drives the mux's one-hot select, counts delivered beats, and gates the mux's downstream ready so that no beat transfers while the mux's internally registered select is changing. It sits between the ADC drivers' tvalid lines, the mux and the PS-side AXIS sink.

## Interface
Parameters:
- BURST_W, 16: width of the burst-length input and the beat counter.
- TIMEOUT_CYC, 64: number of consecutive STREAM cycles without a beat before the grant is released; must be ≥1.

Ports:
- clk  in  1  single clock for the whole block.
- resetn  in  1  reset, synchronous, active-low.
- run  in  1  global enable; sampled only in ARB.
- channel_enable  in  16  per-channel eligibility mask.
- beats_per_grant  in  BURST_W  burst length; sampled at grant; a value of 0 is treated as 1.
- s_axis_tvalid  in  16  tvalid lines of the ADC drivers (request vector).
- mux_m_axis_tvalid  in  1  tvalid output of the mux.
- m_axis_tready  in  1  ready from the downstream sink.
- select_out  out  16  one-hot select to the mux; 0 means none selected.
- mux_m_axis_tready  out  1  ready to the mux: m_axis_tready AND stream_en.
- grant_id  out  4  index of the granted channel.
- grant_active  out  1  high in GRANT and STREAM.
- burst_done  out  1  one-cycle pulse when a burst completes by count.
- timeout_pulse  out  1  one-cycle pulse when a grant is released by timeout.

## Operation
- Requests: req = channel_enable & s_axis_tvalid.
- States:
  - ARB: if run and req≠0, pick the first set bit of req searching upward, with wrap, from last_id+1. Load select_out with that one-hot bit and grant_id with its index. Load the beat counter with max(beats_per_grant,1) and clear the idle counter. Go to GRANT. Otherwise select_out=0 and stay in ARB.
  - GRANT: one settle cycle covering the mux's one-cycle registered select. stream_en=0. Always go to STREAM.
  - STREAM: stream_en=1. A beat is mux_m_axis_tvalid & m_axis_tready.
    - Each beat decrements the counter and clears the idle counter.
    - A cycle with no beat increments the idle counter.
    - The last beat (counter==1 with a beat) pulses burst_done; select_out is cleared and last_id is set to grant_id; go to ARB.
    - If the idle counter reaches TIMEOUT_CYC-1 and there is no beat this cycle, pulse timeout_pulse, clear select_out, set last_id, and go to ARB.
    - If a beat and the timeout threshold coincide, the beat wins: the idle counter clears.
- stream_en is decoded from the state register: it is 1 only in STREAM, and is never combinationally derived from tvalid.
- A run deassertion mid-burst does not abort the burst; it takes effect at the next ARB.
- A change to channel_enable for the granted channel mid-burst does not abort the burst.
- Reset values: state=ARB, select_out=0, grant_id=0, last_id=15 (so the first search starts at channel 0), all pulses 0, both counters 0, mux_m_axis_tready=0.

## Timing
- Grant latency: a request seen in ARB at cycle t gives select_out at t+1 (GRANT) and stream_en at t+2. The mux output reflects the new select from t+2, so no beat is accepted from the wrong channel.
- Release: the beat at cycle t completes the burst. stream_en=0 from t+1, so the stale-select cycle at the mux is gated.
- Minimum arbitration gap is 2 cycles per grant (ARB, GRANT).
- Back-to-back grants to the same channel are allowed when it is the only requester.
- Reset asserted mid-burst: all outputs return to their reset values on the next edge. An in-flight beat on that edge is not counted.

## Structure
- rfsoc_config package: add NUM_ADC_CH=16 and the state enum sched_state_t {ARB, GRANT, STREAM}. The existing ps_axis_width is not used here.
- Sub-module rr_pick16: combinational round-robin picker with inputs req[15:0] and last_id[3:0], and outputs found, pick_id[3:0] and pick_onehot[15:0].
- Registers (FSM, counters, select) live in axis_mux_scheduler.

## Test plan
- After reset, run=1, channel_enable=16'hFFFF, s_axis_tvalid=16'h0009, beats_per_grant=4, sink always ready:
  - select_out=16'h0001, four beats, burst_done.
  - Then select_out=16'h0008, four beats.
  - Then back to channel 0.
  - Exactly 4 mux_m_axis_tready-qualified beats per grant.
- Select-change gating: check that mux_m_axis_tready=0 in every GRANT cycle and in the cycle after each last beat. The mux must never output data from a deselected channel while ready is high.
- Timeout: grant channel 5, TIMEOUT_CYC=8, then drop its tvalid after 2 beats → timeout_pulse exactly 8 idle cycles later, followed by ARB.
- beats_per_grant=0 → exactly one beat per grant. channel_enable=16'h0000 with all tvalid=1 → select_out stays 0.
- run deasserted mid-burst of 10 beats → all 10 beats complete, then select_out=0 and no new grant until run=1.
- resetn pulsed low during STREAM → the next cycle shows select_out=0, state ARB, and no burst_done.
